// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execute-stage ALU: operation request with
// decoded instruction fields and operands, and the registered result.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            op5;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic [1:0]      ALUOp;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  // Requester side (control FSM / bench).
  modport master (
    output in_valid, op5, funct3, funct7b5, funct7b0, ALUOp, srcA, srcB, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // Execute unit side.
  modport slave (
    input  in_valid, op5, funct3, funct7b5, funct7b0, ALUOp, srcA, srcB, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops with a registered result, plus
// the RV32M set on an iterative engine (shift-add multiply, restoring divide)
// that takes exactly XLEN steps. One operation in flight at a time.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_exec_unit_if.slave bus
);
  localparam int              SHW  = $clog2(XLEN);
  localparam logic [SHW-1:0]  LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_ILL} kind_e;

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo} product or {remainder, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]        mop_q, mop_d;     // latched funct3 of the M op
  logic              neg_q, neg_d;     // product / quotient sign
  logic              rneg_q, rneg_d;   // remainder sign (sign of dividend)
  logic              divz_q, divz_d;   // divisor was zero
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  kind_e             kind;
  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, mul_full, div_next;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res;

  // Decode the request fields and compute the single-cycle ALU result.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    kind    = K_ALU;
    alu_res = '0;
    shamt   = bus.srcB[SHW-1:0];
    case (bus.ALUOp)
      2'b00: alu_res = bus.srcA + bus.srcB;
      2'b01: alu_res = bus.srcA - bus.srcB;
      2'b11: kind = K_ILL;
      default: begin
        if (bus.op5 && bus.funct7b0) begin
          if (ENABLE_M) kind = bus.funct3[2] ? K_DIV : K_MUL;
          else          kind = K_ILL;
        end else begin
          case (bus.funct3)
            3'b000: alu_res = (bus.op5 && bus.funct7b5) ? bus.srcA - bus.srcB : bus.srcA + bus.srcB;
            3'b001: alu_res = bus.srcA << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.srcA) < $signed(bus.srcB)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, bus.srcA < bus.srcB};
            3'b100: alu_res = bus.srcA ^ bus.srcB;
            3'b101: begin
              // Kept as separate assignments so the arithmetic shift stays signed.
              if (bus.funct7b5) alu_res = $signed(bus.srcA) >>> shamt;
              else              alu_res = bus.srcA >> shamt;
            end
            3'b110: alu_res = bus.srcA | bus.srcB;
            default: alu_res = bus.srcA & bus.srcB;
          endcase
        end
      end
    endcase
  end

  // Operand signedness per M op, and the magnitudes the engine works on.
  always_comb begin
    if (bus.funct3[2]) begin
      a_signed = !bus.funct3[0];              // div, rem
      b_signed = !bus.funct3[0];
    end else begin
      a_signed = (bus.funct3[1:0] != 2'b11);  // mul, mulh, mulhsu
      b_signed = !bus.funct3[1];              // mul, mulh
    end
    sign_a = a_signed && bus.srcA[XLEN-1];
    sign_b = b_signed && bus.srcB[XLEN-1];
    mag_a  = sign_a ? -bus.srcA : bus.srcA;
    mag_b  = sign_b ? -bus.srcB : bus.srcB;
  end

  // One engine step for each algorithm, and the sign fix-up applied on the last step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    mul_full  = neg_q ? -mul_next : mul_next;
    mul_res   = (mop_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    // A zero divisor leaves remainder = |A| (restored by the sign fix) but the quotient must be all-ones.
    div_res   = mop_q[1] ? (rneg_q ? -rem : rem)
                         : (divz_q ? '1 : (neg_q ? -quo : quo));
  end

  // Next state: accept and dispatch in IDLE, iterate the engine, hold the result in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mop_d     = mop_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    divz_d    = divz_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          illegal_d = 1'b0;
          mop_d     = bus.funct3;
          cnt_d     = '0;
          neg_d     = sign_a ^ sign_b;
          rneg_d    = sign_a;
          divz_d    = (bus.srcB == '0);
          case (kind)
            K_MUL: begin
              acc_d   = {{XLEN{1'b0}}, mag_b};
              opnd_d  = mag_a;
              state_d = S_MUL;
            end
            K_DIV: begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              opnd_d  = mag_b;
              state_d = S_DIV;
            end
            K_ILL: begin
              result_d  = '0;
              illegal_d = 1'b1;
              state_d   = S_DONE;
            end
            default: begin
              result_d = alu_res;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and engine registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      mop_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      divz_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      mop_q     <= mop_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      divz_q    <= divz_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases and randomized requests checked
// against an arithmetic reference model; a second instance is built without
// the M extension.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit_if #(.XLEN(XLEN)) bus0 ();

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the instruction semantics, using 64-bit arithmetic.
  function automatic void model(input logic [1:0] aluop, input logic op5, input logic [2:0] f3,
                                input logic f7b5, input logic f7b0,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, p;
    longint unsigned pu;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; ill = 1'b0; lat = 1;
    case (aluop)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: ill = 1'b1;
      default: begin
        if (op5 && f7b0) begin
          lat = XLEN + 1;
          case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3'd4: if (b == 0) r = '1; else if (ovf) r = a; else begin p = sa / sb; r = p[31:0]; end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) r = a; else if (ovf) r = '0; else begin p = sa % sb; r = p[31:0]; end
            default: r = (b == 0) ? a : a % b;
          endcase
        end else begin
          case (f3)
            3'd0: r = (op5 && f7b5) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (f7b5) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] aluop, input logic op5, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp = aluop; bus.op5 = op5; bus.funct3 = f3;
    bus.funct7b5 = f7b5; bus.funct7b0 = f7b0; bus.srcA = a; bus.srcB = b;
  endtask

  task automatic scramble();
    bus.ALUOp = 2'($urandom); bus.op5 = 1'($urandom); bus.funct3 = 3'($urandom);
    bus.funct7b5 = 1'($urandom); bus.funct7b0 = 1'($urandom);
    bus.srcA = $urandom; bus.srcB = $urandom;
  endtask

  // One request on the M-enabled unit: latency, busy, result, flags, optional output stall.
  task automatic run_op(input string tag, input logic [1:0] aluop, input logic op5, input logic [2:0] f3,
                        input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ei, input int elat, input int hold);
    int cyc;
    bit busy_ok, stable_ok;
    @(negedge clk);
    check({tag, "/in_ready_idle"}, bus.in_ready, 1);
    bus.out_ready = (hold == 0);
    drive(aluop, op5, f3, f7b5, f7b0, a, b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
    cyc = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && cyc < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "/out_valid"}, bus.out_valid, 1);
    check({tag, "/latency"}, cyc, elat);
    check({tag, "/busy"}, busy_ok, 1);
    check({tag, "/result"}, bus.result, er);
    check({tag, "/zero"}, bus.zero, er == 0);
    check({tag, "/illegal"}, bus.illegal, ei);
    if (hold > 0) begin
      stable_ok = 1'b1;
      bus.in_valid = 1'b1;  // must be ignored while the result is pending
      repeat (hold) begin
        @(negedge clk);
        if (!bus.out_valid || bus.result !== er || bus.illegal !== ei || bus.in_ready) stable_ok = 1'b0;
      end
      check({tag, "/stall_stable"}, stable_ok, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "/ready_after"}, bus.in_ready, 1);
    check({tag, "/valid_drop"}, bus.out_valid, 0);
  endtask

  // One request on the unit built without the M extension.
  task automatic run_nom(input string tag, input logic [1:0] aluop, input logic op5, input logic [2:0] f3,
                         input logic f7b0, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei);
    @(negedge clk);
    bus0.out_ready = 1'b1;
    bus0.ALUOp = aluop; bus0.op5 = op5; bus0.funct3 = f3; bus0.funct7b5 = 1'b0;
    bus0.funct7b0 = f7b0; bus0.srcA = a; bus0.srcB = b;
    bus0.in_valid = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check({tag, "/out_valid"}, bus0.out_valid, 1);
    check({tag, "/result"}, bus0.result, er);
    check({tag, "/zero"}, bus0.zero, er == 0);
    check({tag, "/illegal"}, bus0.illegal, ei);
    @(negedge clk);
    check({tag, "/ready_after"}, bus0.in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  aluop;
    logic        op5, f7b5, f7b0, ei;
    logic [2:0]  f3;
    logic [31:0] a, b, er;
    int          elat;

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; drive(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.ALUOp = 2'b00; bus0.op5 = 1'b0;
    bus0.funct3 = 3'd0; bus0.funct7b5 = 1'b0; bus0.funct7b0 = 1'b0; bus0.srcA = '0; bus0.srcB = '0;
    repeat (3) @(negedge clk);
    check("rst/in_ready", bus.in_ready, 1);
    check("rst/out_valid", bus.out_valid, 0);
    check("rst/result", bus.result, 0);
    check("rst/zero", bus.zero, 1);
    check("rst/illegal", bus.illegal, 0);
    reset_n = 1'b1;

    // Directed ALU cases
    run_op("sub_r",   2'b10, 1, 3'b000, 1, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 0);
    run_op("sub_op",  2'b01, 0, 3'b000, 0, 0, 32'd9, 32'd9, 32'h0, 0, 1, 0);
    run_op("sra",     2'b10, 1, 3'b101, 1, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1, 0);
    run_op("srl",     2'b10, 1, 3'b101, 0, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1, 0);
    run_op("slt",     2'b10, 1, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1, 0);
    run_op("sltu",    2'b10, 1, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0);
    run_op("rsvd",    2'b11, 1, 3'b000, 0, 0, 32'd3, 32'd4, 32'd0, 1, 1, 0);
    // Directed M cases
    run_op("mul",     2'b10, 1, 3'b000, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 33, 0);
    run_op("mulhu",   2'b10, 1, 3'b011, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 0);
    run_op("mulh",    2'b10, 1, 3'b001, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 33, 0);
    run_op("mulhsu",  2'b10, 1, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 33, 0);
    run_op("div",     2'b10, 1, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 33, 0);
    run_op("rem",     2'b10, 1, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 33, 0);
    run_op("divu_z",  2'b10, 1, 3'b101, 0, 1, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 33, 0);
    run_op("rem_z",   2'b10, 1, 3'b110, 0, 1, 32'd7, 32'd0, 32'd7, 0, 33, 0);
    run_op("div_ovf", 2'b10, 1, 3'b100, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 33, 0);
    run_op("rem_ovf", 2'b10, 1, 3'b110, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 33, 0);
    // Output stall with in_valid asserted during the stall
    run_op("stall",   2'b00, 0, 3'b000, 0, 0, 32'd40, 32'd2, 32'd42, 0, 1, 10);

    // Reset in the middle of a divide
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort/in_ready", bus.in_ready, 1);
    check("abort/out_valid", bus.out_valid, 0);
    check("abort/result", bus.result, 0);
    check("abort/zero", bus.zero, 1);
    check("abort/illegal", bus.illegal, 0);
    @(negedge clk);
    check("abort/no_output", bus.out_valid, 0);
    reset_n = 1'b1;
    run_op("post_rst_add", 2'b00, 0, 3'b000, 0, 0, 32'd1, 32'd2, 32'd3, 0, 1, 0);

    // Build without the M extension
    run_nom("nom_mul",  2'b10, 1, 3'b000, 1, 32'd6, 32'd7, 32'd0, 1);
    run_nom("nom_rsvd", 2'b11, 0, 3'b000, 0, 32'd6, 32'd7, 32'd0, 1);
    run_nom("nom_add",  2'b10, 0, 3'b000, 0, 32'd6, 32'd7, 32'd13, 0);

    // Randomized requests against the model
    for (int i = 0; i < 150; i++) begin
      aluop = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
      op5   = 1'($urandom);
      f3    = 3'($urandom);
      f7b5  = 1'($urandom);
      f7b0  = ($urandom_range(0, 2) != 0);
      a     = pick();
      b     = pick();
      model(aluop, op5, f3, f7b5, f7b0, a, b, er, ei, elat);
      run_op("rnd", aluop, op5, f3, f7b5, f7b0, a, b, er, ei, elat, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
